// File: rtl/posit_encode_pipe.sv
// posit_encode_pipe: two-stage packer from unpacked posit fields to a packed
// WIDTH-bit posit. Stage 1 builds the regime run and the guard and sticky bits.
// Stage 2 applies round-to-nearest-even, handles zero and inf, and packs the
// result. A valid/ready handshake is used on both sides.
module posit_encode_pipe #(
    parameter int WIDTH = 8,
    parameter int ES    = 1,
    localparam int MAXR = WIDTH - 2,
    localparam int RB   = $clog2(2 * MAXR + 1),
    localparam int EB   = RB + ES,
    localparam int FB   = WIDTH - 3 - ES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic             in_is_zero,
    input  logic             in_is_inf,
    input  logic [EB-1:0]    in_exponent,
    input  logic [FB-1:0]    in_fraction,
    input  logic             in_round,
    input  logic             in_sticky,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bits
);

    // The tail holds the es bits, the fraction, round and sticky. Its width is
    // always WIDTH-1.
    localparam int TW   = ES + FB + 2;
    // The regime run is at most MAXR+1 bits, plus its terminator. This width
    // keeps every stream bit, so guard and sticky are exact.
    localparam int SWID = WIDTH + TW;

    logic [TW-1:0] tail;
    if (ES > 0) begin : g_es
        assign tail = {in_exponent[ES-1:0], in_fraction, in_round, in_sticky};
    end else begin : g_no_es
        assign tail = {in_fraction, in_round, in_sticky};
    end

    // Pipeline state
    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q, s1_sign_d;
    logic             s1_zero_q, s1_zero_d;
    logic             s1_inf_q, s1_inf_d;
    logic             s1_max_q, s1_max_d;
    logic [WIDTH-2:0] s1_kept_q, s1_kept_d;
    logic             s1_guard_q, s1_guard_d;
    logic             s1_sticky_q, s1_sticky_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_bits_q, s2_bits_d;

    logic s2_adv, s1_adv;

    // Handshake: a stage may load when it is empty or when its contents move on.
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = !reset && s1_adv;
    end

    assign out_valid = s2_valid_q;
    assign out_bits  = s2_bits_q;

    // Stage 1: build the regime-shifted stream and split it into kept, guard and sticky.
    logic [RB-1:0]   ureg;
    logic            rbit;
    logic [RB-1:0]   run_len;
    logic [SWID-1:0] stream;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_zero_d   = s1_zero_q;
        s1_inf_d    = s1_inf_q;
        s1_max_d    = s1_max_q;
        s1_kept_d   = s1_kept_q;
        s1_guard_d  = s1_guard_q;
        s1_sticky_d = s1_sticky_q;

        ureg    = in_exponent[EB-1:ES];
        rbit    = ureg >= RB'(MAXR);
        // A run of k+1 ones when k >= 0, or a run of -k zeros when k < 0.
        run_len = rbit ? (ureg - RB'(MAXR) + RB'(1)) : (RB'(MAXR) - ureg);
        // Place the terminator and the tail at the top, then shift in the run.
        stream  = {~rbit, tail, {(WIDTH - 1){1'b0}}} >> run_len;
        if (rbit) begin
            stream = stream | ~({SWID{1'b1}} >> run_len);
        end

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d   = in_sign;
                s1_zero_d   = in_is_zero;
                s1_inf_d    = in_is_inf;
                s1_max_d    = ureg > RB'(2 * MAXR);
                s1_kept_d   = stream[SWID-1 -: WIDTH-1];
                s1_guard_d  = stream[SWID-WIDTH];
                s1_sticky_d = |stream[SWID-WIDTH-1:0];
            end
        end
    end

    // Stage 2: round to nearest even, saturate at maxpos, then apply zero and inf.
    logic             inc;
    logic [WIDTH-2:0] mag;

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_bits_d  = s2_bits_q;

        // When kept is already maxpos, rounding up is suppressed so the value saturates.
        inc = s1_guard_q && (s1_sticky_q || s1_kept_q[0]) && !(&s1_kept_q);
        mag = s1_kept_q + {{(WIDTH - 2){1'b0}}, inc};
        if (s1_max_q) begin
            mag = '1;
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                if (s1_inf_q) begin
                    s2_bits_d = {1'b1, {(WIDTH - 1){1'b0}}};
                end else if (s1_zero_q) begin
                    s2_bits_d = '0;
                end else begin
                    s2_bits_d = {s1_sign_q, mag};
                end
            end
        end
    end

    // Pipeline registers; reset discards all in-flight data.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_max_q    <= 1'b0;
            s1_kept_q   <= '0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_bits_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_zero_q   <= s1_zero_d;
            s1_inf_q    <= s1_inf_d;
            s1_max_q    <= s1_max_d;
            s1_kept_q   <= s1_kept_d;
            s1_guard_q  <= s1_guard_d;
            s1_sticky_q <= s1_sticky_d;
            s2_valid_q  <= s2_valid_d;
            s2_bits_q   <= s2_bits_d;
        end
    end

endmodule
